// File: rtl/tdm_demultiplexer_1_to_8_pkg.sv
// Shared constants and types for the 8-channel TDM link (mux and demux stages).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: channel count, channel index width, demux state encoding and a
// helper that returns the LSB position of a channel slice in a packed frame.
package tdm_demultiplexer_1_to_8_pkg;

  localparam int CHANNELS = 8;
  localparam int CTRL_W   = 3;

  // IDLE: not yet aligned to a frame; COLLECT: aligned, filling channel slots.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Channel k of a packed frame occupies bits [chan_lsb(k, width) +: width].
  function automatic int chan_lsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/tdm_demultiplexer_1_to_8_if.sv
// Link-side and frame-side signal bundle of the TDM demultiplexer.
// Latency: n/a (wiring only).
// Backpressure: none; the link is push-only, samples are never stalled.
//
// Signals: in/in_valid/frame_start (serial link), out/out_valid (parallel
// frame), control (next channel slot), sync_error (mid-frame resync strobe).
// With TDM_DEMUX_FRAME_CNT_EN defined, frame_count[7:0] is added.
// Modports: master = link source / frame consumer, slave = demultiplexer.
interface tdm_demultiplexer_1_to_8_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0]                                            in;
  logic                                                        in_valid;
  logic                                                        frame_start;
  logic [tdm_demultiplexer_1_to_8_pkg::CHANNELS*WIDTH-1:0]     out;
  logic                                                        out_valid;
  logic [tdm_demultiplexer_1_to_8_pkg::CTRL_W-1:0]             control;
  logic                                                        sync_error;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0]                                                  frame_count;
`endif

  modport master (
    output in, in_valid, frame_start,
    input  out, out_valid, control, sync_error
`ifdef TDM_DEMUX_FRAME_CNT_EN
    , input frame_count
`endif
  );

  modport slave (
    input  in, in_valid, frame_start,
    output out, out_valid, control, sync_error
`ifdef TDM_DEMUX_FRAME_CNT_EN
    , output frame_count
`endif
  );

endinterface

// File: rtl/tdm_demultiplexer_1_to_8_channel_counter.sv
// Channel slot counter: load-to-1 on frame start, increment per sample, wrap flag.
// Latency: count updates one clock after load/inc; wrap is combinational.
// Backpressure: none; inc is simply held off while no sample is present.
//
// Ports: clk, rst_n, load (restart at slot 1), inc (advance one slot),
// count (slot the next sample goes to), wrap (last slot written this cycle).
module tdm_channel_counter #(
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [CTRL_W-1:0] count,
  output logic              wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      // frame_start carries channel 0, so the next sample belongs to slot 1
      count <= CTRL_W'(1);
    end else if (inc) begin
      count <= count + CTRL_W'(1);
    end
  end

  // Top slot being written: frame completes and count rolls back to 0.
  assign wrap = inc & ~load & (count == '1);

endmodule

// File: rtl/tdm_demultiplexer_1_to_8.sv
// 1-to-8 TDM demultiplexer: collects serial samples into slots, latches full frames.
// Latency: 1 clock from channel-7 sample to out/out_valid; sync_error 1 clock after bad frame_start.
// Backpressure: none; every valid sample is consumed, in_valid gaps of any length hold state.
//
// Ports: clk, rst_n (async active-low), bus (slave modport of
// tdm_demultiplexer_1_to_8_if). Optional feature macro TDM_DEMUX_FRAME_CNT_EN
// adds bus.frame_count: completed frames mod 256, cleared on sync_error.
module tdm_demultiplexer_1_to_8
  import tdm_demultiplexer_1_to_8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  tdm_demultiplexer_1_to_8_if.slave       bus
);

  // Channel 7 is never parked: it goes straight from the link into out.
  localparam int SHADOW_W = (CHANNELS - 1) * WIDTH;
  localparam int FRAME_W  = CHANNELS * WIDTH;

  state_t              state;
  logic [SHADOW_W-1:0] shadow;
  logic [FRAME_W-1:0]  out_q;
  logic                out_valid_q;
  logic                sync_error_q;
  logic [CTRL_W-1:0]   control;
  logic                load;
  logic                inc;
  logic                wrap;
  logic                mid_frame;

  // frame_start restarts alignment in either state; plain samples only count once aligned.
  assign load      = bus.in_valid & bus.frame_start;
  assign inc       = (state == COLLECT) & bus.in_valid & ~bus.frame_start;
  // A frame_start here means the partial frame in the shadow slots is abandoned.
  assign mid_frame = (state == COLLECT) & (control != '0);

  tdm_channel_counter #(
    .CTRL_W (CTRL_W)
  ) u_channel_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .count (control),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      out_valid_q  <= wrap;
      sync_error_q <= load & mid_frame;

      if (load) begin
        state <= COLLECT;
      end

      for (int k = 0; k < CHANNELS - 1; k++) begin
        if ((load && (k == 0)) || (inc && (control == CTRL_W'(k)))) begin
          shadow[chan_lsb(k, WIDTH) +: WIDTH] <= bus.in;
        end
      end

      // Atomic frame update: slots 0..6 from shadow, slot 7 from the live sample.
      if (wrap) begin
        out_q <= {bus.in, shadow};
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sync_error = sync_error_q;
  assign bus.control    = control;

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else if (load & mid_frame) begin
      frame_count_q <= '0;
    end else if (wrap) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
`endif

endmodule
